clk_enable_gen: RTL and testbench

Programmable multi-channel clock-enable generator replacing the fixed free-running counter tap that currently slows the CPU. Each channel produces a single-cycle `tick` enable plus a legacy `slow_clk` square wave from one `clk` domain, with a runtime divisor and run/halt/single-step control. It sits at top level between the board clock and the CPU/UART consumers, so all logic stays on `clk` and no derived clocks are used.

---
 rtl/clk_gen_pkg.sv | 24 ++
 rtl/clk_enable_gen_if.sv | 14 +
 rtl/clk_gen_channel.sv | 80 ++++++++
 rtl/clk_enable_gen.sv | 43 ++++
 tb/tb_clk_enable_gen.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_gen_pkg.sv
// Shared types and defaults for the clock-enable generator.
// Mode encodings, parameter defaults and the mode decode helper.
package clk_gen_pkg;

    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_DIV_W     = 16;
    localparam int DEF_RESET_DIV = 32;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'b00,
        MODE_HALT = 2'b01,
        MODE_STEP = 2'b10
    } mode_t;

    // The reserved encoding 11 parks the channel like HALT.
    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'b00:   decode_mode = MODE_RUN;
            2'b10:   decode_mode = MODE_STEP;
            default: decode_mode = MODE_HALT;
        endcase
    endfunction

endpackage

// File: rtl/clk_enable_gen_if.sv
// Configuration write bus for clk_enable_gen.
// cfg_we strobes cfg_div/cfg_mode into channel cfg_ch.
interface clk_enable_gen_if #(
    parameter int CH_W  = 1,
    parameter int DIV_W = 16
);
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [1:0]       cfg_mode;

    modport master (output cfg_we, cfg_ch, cfg_div, cfg_mode);
    modport slave  (input  cfg_we, cfg_ch, cfg_div, cfg_mode);
endinterface

// File: rtl/clk_gen_channel.sv
// One clock-enable channel: period counter, divisor staging, mode.
// Ports: we/div_in/mode_in config write, step request; tick, slow_clk, halted.
module clk_gen_channel
    import clk_gen_pkg::*;
#(
    parameter int DIV_W     = DEF_DIV_W,
    parameter int RESET_DIV = DEF_RESET_DIV
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             we,
    input  logic [DIV_W-1:0] div_in,
    input  logic [1:0]       mode_in,
    input  logic             step,
    output logic             tick,
    output logic             slow_clk,
    output logic             halted
);

    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] div_act, div_act_n;
    logic [DIV_W-1:0] div_pend, div_pend_n;
    logic [DIV_W-1:0] n_per;
    mode_t            mode, mode_n;
    logic             active, active_n;
    logic             wrap;

    // Divisors 0 and 1 both mean a one-cycle period.
    assign n_per = (div_act <= DIV_W'(1)) ? DIV_W'(1) : div_act;
    assign wrap  = active && (cnt == n_per - DIV_W'(1));

    assign tick     = wrap;
    assign slow_clk = active && (cnt >= (n_per >> 1));
    assign halted   = !active;

    always_comb begin
        mode_n     = we ? decode_mode(mode_in) : mode;
        div_pend_n = we ? div_in : div_pend;
        div_act_n  = div_act;
        cnt_n      = cnt;
        active_n   = active;
        // A write landing on the wrap edge already shapes the next period.
        if (wrap || !active) begin
            div_act_n = div_pend_n;
        end
        if (active) begin
            if (wrap) begin
                cnt_n    = '0;
                active_n = (mode_n == MODE_RUN);
            end else begin
                cnt_n = cnt + DIV_W'(1);
            end
        end else begin
            cnt_n = '0;
            if (mode_n == MODE_RUN) begin
                active_n = 1'b1;
            // step is judged against the mode held before any same-cycle write
            end else if (mode == MODE_STEP && step) begin
                active_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            div_act  <= DIV_W'(RESET_DIV);
            div_pend <= DIV_W'(RESET_DIV);
            mode     <= MODE_RUN;
            active   <= 1'b1;
        end else begin
            cnt      <= cnt_n;
            div_act  <= div_act_n;
            div_pend <= div_pend_n;
            mode     <= mode_n;
            active   <= active_n;
        end
    end

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator on a single clk domain.
// Ports: clk, resetn, cfg (write bus), step[], tick[], slow_clk[], halted[].
module clk_enable_gen
    import clk_gen_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DIV_W     = DEF_DIV_W,
    parameter int RESET_DIV = DEF_RESET_DIV
) (
    input  logic              clk,
    input  logic              resetn,
    clk_enable_gen_if.slave   cfg,
    input  logic [NUM_CH-1:0] step,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] slow_clk,
    output logic [NUM_CH-1:0] halted
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_we;

        // Selector codes at or above NUM_CH match no channel.
        assign ch_we = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

        clk_gen_channel #(
            .DIV_W     (DIV_W),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk      (clk),
            .resetn   (resetn),
            .we       (ch_we),
            .div_in   (cfg.cfg_div),
            .mode_in  (cfg.cfg_mode),
            .step     (step[i]),
            .tick     (tick[i]),
            .slow_clk (slow_clk[i]),
            .halted   (halted[i])
        );
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Scoreboard bench for clk_enable_gen with three channels.
// Expected ticks and output snapshots are queued ahead; a monitor compares.
module tb_clk_enable_gen;

    localparam int NCH = 3;
    localparam int DW  = 16;
    localparam int CW  = 2;

    typedef struct {
        int         t;
        int         sel;
        logic [2:0] mask;
        logic [2:0] exp;
    } snap_t;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [NCH-1:0] step;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] slow_clk;
    logic [NCH-1:0] halted;

    int    cyc = 0;
    int    base = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    lo [NCH];
    int    hi [NCH];
    int    q0 [$];
    int    q1 [$];
    int    q2 [$];
    snap_t snaps [$];

    clk_enable_gen_if #(.CH_W(CW), .DIV_W(DW)) cfg_if ();

    clk_enable_gen #(
        .NUM_CH    (NCH),
        .DIV_W     (DW),
        .RESET_DIV (32)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .cfg      (cfg_if.slave),
        .step     (step),
        .tick     (tick),
        .slow_clk (slow_clk),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sel_name(input int s);
        case (s)
            0:       sel_name = "tick";
            1:       sel_name = "slow_clk";
            2:       sel_name = "halted";
            default: sel_name = "drain";
        endcase
    endfunction

    task automatic push_tick(input int c, input int x);
        case (c)
            0:       q0.push_back(base + x);
            1:       q1.push_back(base + x);
            default: q2.push_back(base + x);
        endcase
    endtask

    task automatic push_snap(input int x, input int s,
                             input logic [2:0] m,
                             input logic [2:0] e);
        snap_t n;
        n.t    = base + x;
        n.sel  = s;
        n.mask = m;
        n.exp  = e;
        snaps.push_back(n);
    endtask

    task automatic tick_seen(input int c);
        int e;
        bit got;
        e   = 0;
        got = 1'b0;
        case (c)
            0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            default:
               if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL tick%0d unexpected at X=%0d", c, cyc - base);
        end else if (e != cyc) begin
            n_fail++;
            $display("FAIL tick%0d at X=%0d, required X=%0d",
                     c, cyc - base, e - base);
        end
    endtask

    always @(negedge clk) begin
        logic [2:0] v;
        if (resetn) begin
            for (int c = 0; c < NCH; c++) begin
                if (tick[c] && cyc >= lo[c] && cyc <= hi[c]) tick_seen(c);
            end
        end
        for (int i = snaps.size() - 1; i >= 0; i--) begin
            if (snaps[i].t == cyc) begin
                case (snaps[i].sel)
                    0:       v = tick;
                    1:       v = slow_clk;
                    2:       v = halted;
                    default: v = {q2.size() != 0, q1.size() != 0,
                                  q0.size() != 0};
                endcase
                n_chk++;
                if ((v & snaps[i].mask) != (snaps[i].exp & snaps[i].mask)) begin
                    n_fail++;
                    $display("FAIL %s at X=%0d got %b required %b",
                             sel_name(snaps[i].sel), cyc - base,
                             v & snaps[i].mask,
                             snaps[i].exp & snaps[i].mask);
                end
                snaps.delete(i);
            end
        end
    end

    task automatic at(input int x);
        while (cyc - base < x) @(negedge clk);
    endtask

    task automatic cfg_write(input int c, input int d, input logic [1:0] m);
        cfg_if.cfg_we   = 1'b1;
        cfg_if.cfg_ch   = CW'(c);
        cfg_if.cfg_div  = DW'(d);
        cfg_if.cfg_mode = m;
        @(negedge clk);
        cfg_if.cfg_we   = 1'b0;
    endtask

    task automatic pulse(input logic [NCH-1:0] p);
        step = p;
        @(negedge clk);
        step = '0;
    endtask

    task automatic push_clean_start();
        for (int x = 0; x < 64; x++) begin
            push_snap(x, 1, 3'b111, {3{(x % 32) >= 16}});
            push_snap(x, 2, 3'b111, 3'b000);
        end
        for (int c = 0; c < NCH; c++) begin
            push_tick(c, 31);
            push_tick(c, 63);
        end
    endtask

    initial begin
        step            = '0;
        cfg_if.cfg_we   = 1'b0;
        cfg_if.cfg_ch   = '0;
        cfg_if.cfg_div  = '0;
        cfg_if.cfg_mode = 2'b00;
        for (int c = 0; c < NCH; c++) begin
            lo[c] = 0;
            hi[c] = -1;
        end

        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            push_snap(cyc + 1, s, 3'b111, 3'b000);
            push_snap(cyc + 2, s, 3'b111, 3'b000);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        base   = cyc;

        push_clean_start();
        push_tick(0, 95);
        for (int x = 103; x <= 287; x += 8) push_tick(0, x);
        push_tick(1, 95);
        push_tick(1, 232);
        push_tick(1, 264);
        push_tick(1, 296);
        push_tick(2, 95);
        push_tick(2, 127);
        push_tick(2, 144);
        push_tick(2, 154);
        lo[0] = base; hi[0] = base + 287;
        lo[1] = base; hi[1] = base + 296;
        lo[2] = base; hi[2] = base + 331;

        push_snap(95, 2, 3'b010, 3'b000);
        push_snap(96, 2, 3'b010, 3'b010);
        for (int x = 96; x < 112; x++)
            push_snap(x, 1, 3'b001, {2'b00, ((x - 96) % 8) >= 4});
        push_snap(140, 2, 3'b100, 3'b100);
        push_snap(141, 2, 3'b100, 3'b000);
        push_snap(141, 1, 3'b100, 3'b000);
        push_snap(143, 1, 3'b100, 3'b100);
        push_snap(144, 2, 3'b100, 3'b000);
        push_snap(145, 2, 3'b100, 3'b100);
        push_snap(150, 2, 3'b110, 3'b110);
        push_snap(151, 2, 3'b100, 3'b000);
        push_snap(154, 2, 3'b100, 3'b000);
        push_snap(155, 2, 3'b100, 3'b100);
        push_snap(162, 2, 3'b010, 3'b010);
        push_snap(200, 2, 3'b010, 3'b010);
        push_snap(201, 2, 3'b010, 3'b000);
        for (int x = 300; x < 308; x++) begin
            push_snap(x, 0, 3'b011, 3'b011);
            push_snap(x, 1, 3'b011, 3'b011);
        end
        push_snap(300, 2, 3'b111, 3'b100);
        for (int x = 312; x < 317; x++) begin
            push_snap(x, 0, 3'b011, 3'b011);
            push_snap(x, 2, 3'b111, 3'b100);
        end
        push_snap(320, 3, 3'b111, 3'b000);
        push_snap(332, 2, 3'b100, 3'b000);
        push_snap(332, 0, 3'b011, 3'b011);
        for (int s = 0; s < 3; s++) push_snap(333, s, 3'b111, 3'b000);

        at(69);  cfg_write(1, 32, 2'b01);
        at(74);  cfg_write(0, 8, 2'b00);
        at(120); cfg_write(2, 4, 2'b10);
        at(140); pulse(3'b100);
        at(142); pulse(3'b100);
        at(150); pulse(3'b100);
        at(160); pulse(3'b011);
        at(200); cfg_write(1, 32, 2'b00);
        at(280); cfg_write(0, 0, 2'b00);
        at(282); cfg_write(1, 1, 2'b00);
        at(310); cfg_write(3, 5, 2'b11);
        at(330); pulse(3'b100);
        at(332);
        @(posedge clk);
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        base   = cyc;

        push_clean_start();
        for (int c = 0; c < NCH; c++) begin
            lo[c] = base;
            hi[c] = base + 70;
        end
        push_snap(72, 3, 3'b111, 3'b000);
        at(74);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
